// File: rtl/immediate_generator.sv
// -----------------------------------------------------------------------------
// immediate_generator
//
// Dual-lane RV64 immediate generator for a two-wide decode stage. Each lane
// classifies its 32-bit instruction word by the full 7-bit opcode. It then
// produces the sign-extended 64-bit immediate for the I, S, B, U or J format.
// Every other opcode yields zero.
//
// Both lanes use the same decode function. The combinational results are also
// captured in a pair of registers for the decode/execute pipeline boundary.
//
// Ports:
//   clk     in   1   pipeline clock
//   rst     in   1   asynchronous, active-high reset (registered outputs only)
//   instrA  in  32   lane A instruction word
//   instrB  in  32   lane B instruction word
//   immA    out 64   lane A immediate, combinational
//   immB    out 64   lane B immediate, combinational
//   immA_q  out 64   lane A immediate, registered (1-cycle latency)
//   immB_q  out 64   lane B immediate, registered (1-cycle latency)
//
// Configuration:
//   IMM_CSR_EN  When defined, SYSTEM instructions with funct3[2]=1 (CSRRWI,
//               CSRRSI, CSRRCI) return the zero-extended 5-bit uimm taken
//               from instr[19:15]. When undefined, SYSTEM always returns 0.
// -----------------------------------------------------------------------------
module immediate_generator (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrA,
  input  logic [31:0] instrB,
  output logic [63:0] immA,
  output logic [63:0] immB,
  output logic [63:0] immA_q,
  output logic [63:0] immB_q
);

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Shared per-lane decode. The sign bit is always instr[31].
  function automatic logic [63:0] decode_imm(input logic [31:0] instr);
    logic [63:0] imm;
    imm = 64'h0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
        // Shift amounts are not special-cased; funct6/funct7 pass through.
        imm = {{52{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
               instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = {{32{instr[31]}}, instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
               instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
`ifdef IMM_CSR_EN
        // funct3[2] selects the immediate CSR forms; uimm is zero-extended.
        if (instr[14]) begin
          imm = {59'h0, instr[19:15]};
        end else begin
          imm = 64'h0;
        end
`else
        imm = 64'h0;
`endif
      end
      default: begin
        imm = 64'h0;
      end
    endcase
    return imm;
  endfunction

  logic [63:0] imm_a_d;
  logic [63:0] imm_b_d;

  // Combinational decode of both lanes; this is also the register next-state.
  always_comb begin
    imm_a_d = decode_imm(instrA);
    imm_b_d = decode_imm(instrB);
  end

  assign immA = imm_a_d;
  assign immB = imm_b_d;

  // Pipeline-boundary copy: loads every cycle and clears asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      immA_q <= 64'h0;
      immB_q <= 64'h0;
    end else begin
      immA_q <= imm_a_d;
      immB_q <= imm_b_d;
    end
  end

endmodule

// File: tb/tb_immediate_generator.sv
module tb_immediate_generator;

  logic        clk;
  logic        rst;
  logic [31:0] instrA;
  logic [31:0] instrB;
  logic [63:0] immA;
  logic [63:0] immB;
  logic [63:0] immA_q;
  logic [63:0] immB_q;

  int n_vec;
  int n_err;
  logic chk_en;
  logic [63:0] exp_qa;
  logic [63:0] exp_qb;

  immediate_generator dut (
    .clk    (clk),
    .rst    (rst),
    .instrA (instrA),
    .instrB (instrB),
    .immA   (immA),
    .immB   (immB),
    .immA_q (immA_q),
    .immB_q (immB_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the immediate as a signed value, built by arithmetic on fields.
  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint sw;
    longint v;
    sw = longint'($signed(w));          // whole word as a signed number
    case (w[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111:
        v = sw >>> 20;
      7'b0100011:
        v = (sw >>> 25) * 64'sd32 + longint'(w[11:7]);
      7'b1100011:
        v = (sw >>> 31) * 64'sd4096 + longint'(w[7]) * 64'sd2048
          + longint'(w[30:25]) * 64'sd32 + longint'(w[11:8]) * 64'sd2;
      7'b0110111, 7'b0010111:
        v = (sw >>> 12) * 64'sd4096;
      7'b1101111:
        v = (sw >>> 31) * 64'sd1048576 + longint'(w[19:12]) * 64'sd4096
          + longint'(w[20]) * 64'sd2048 + longint'(w[30:21]) * 64'sd2;
`ifdef IMM_CSR_EN
      7'b1110011:
        v = w[14] ? longint'(w[19:15]) : 64'sd0;
`endif
      default:
        v = 64'sd0;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected registered outputs: one-cycle delayed reference, cleared by rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_qa <= 64'h0;
      exp_qb <= 64'h0;
    end else begin
      exp_qa <= ref_imm(instrA);
      exp_qb <= ref_imm(instrB);
    end
  end

  // Per-cycle compare of all four outputs against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_immA",   immA,   ref_imm(instrA));
      check("cmp_immB",   immB,   ref_imm(instrB));
      check("cmp_immA_q", immA_q, exp_qa);
      check("cmp_immB_q", immB_q, exp_qb);
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
            7'b0110011, 7'b0001111};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      w[6:0] = ops[$urandom_range(0, 11)];
    end
    return w;
  endfunction

  // Drive one word into both lanes and check against a hand-computed value.
  task automatic directed(input string name, input logic [31:0] w,
                          input logic [63:0] exp);
    @(posedge clk);
    #2;
    instrA = w;
    instrB = w;
    #1;
    check({name, "_A"}, immA, exp);
    check({name, "_B"}, immB, exp);
  endtask

  initial begin
    logic [63:0] csr_exp;
    n_vec  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    instrA = 32'h0;
    instrB = 32'h0;
    rst    = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("reset_immA_q", immA_q, 64'h0);
    check("reset_immB_q", immB_q, 64'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

`ifdef IMM_CSR_EN
    csr_exp = 64'd17;
`else
    csr_exp = 64'd0;
`endif
    directed("addi5",   32'h00510093, 64'd5);
    directed("xori_m5", {12'hFFB, 5'd2, 3'b100, 5'd1, 7'b0010011}, -64'sd5);
    directed("lw4",     {12'd4,   5'd2, 3'b010, 5'd1, 7'b0000011}, 64'd4);
    directed("lb_m4",   {12'hFFC, 5'd3, 3'b000, 5'd1, 7'b0000011}, -64'sd4);
    directed("jalr4",   {12'd4,   5'd1, 3'b000, 5'd0, 7'b1100111}, 64'd4);
    directed("jalr_m4", {12'hFFC, 5'd1, 3'b000, 5'd0, 7'b1100111}, -64'sd4);
    directed("sw4",     {7'b0000000, 5'd1, 5'd2, 3'b010, 5'b00100, 7'b0100011}, 64'd4);
    directed("sw_m28",  {7'b1111111, 5'd1, 5'd2, 3'b010, 5'b00100, 7'b0100011}, -64'sd28);
    directed("beq4",    {1'b0, 6'd0, 5'd1, 5'd2, 3'b000, 4'b0010, 1'b0, 7'b1100011}, 64'd4);
    directed("beq_m4092", {1'b1, 6'd0, 5'd1, 5'd2, 3'b000, 4'b0010, 1'b0, 7'b1100011},
             -64'sd4092);
    directed("lui4096", {20'h00001, 5'd1, 7'b0110111}, 64'd4096);
    directed("lui_m4096", {20'hFFFFF, 5'd1, 7'b0110111}, 64'hFFFFFFFFFFFFF000);
    directed("jal4098", {20'b00000000001000000001, 5'd1, 7'b1101111}, 64'd4098);
    directed("jal2048", {20'b00000000000100000000, 5'd1, 7'b1101111}, 64'd2048);
    directed("add0",    32'h002081B3, 64'd0);
    directed("csrrwi17", {12'h300, 5'd17, 3'b101, 5'd1, 7'b1110011}, csr_exp);
    directed("csrrw0",  {12'h300, 5'd17, 3'b001, 5'd1, 7'b1110011}, 64'd0);

    // Randomized run checked every cycle by the compare process.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      instrA = rand_instr();
      instrB = rand_instr();
    end

    // Mid-run reset: registered outputs must clear without a clock edge.
    @(posedge clk);
    #2;
    check("pre_rst_nonzero_ref", {63'h0, (immA_q == exp_qa)}, 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_immA_q", immA_q, 64'h0);
    check("async_rst_immB_q", immB_q, 64'h0);
    check("rst_comb_immA", immA, ref_imm(instrA));
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_immA_q", immA_q, 64'h0);
    #1;
    rst = 1'b0;
    instrA = 32'h00510093;
    instrB = 32'h002081B3;
    #1;
    check("post_rst_immA_comb", immA, 64'd5);
    check("post_rst_immA_q_wait", immA_q, 64'h0);
    @(posedge clk);
    #1;
    check("post_rst_immA_q", immA_q, 64'd5);
    check("post_rst_immB_q", immB_q, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
